// File: rtl/activation.sv
// activation: serial weighted-sum neuron activation.
// One evaluation snapshots the neuron mask and the packed sign-magnitude
// weights, then accumulates one selected weight per cycle into a signed
// accumulator. At the end it converts the sum to a clamped sign-magnitude
// result on y and pulses done for one cycle.
// Optional feature: define ACTIVATION_SAT_FLAG_EN to add the 'sat' output,
// which flags that the result magnitude was clamped.
module activation #(
    parameter int N_NEURONS = 20,
    parameter int W_WIDTH   = 9
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_NEURONS-1:0]           neurons,
    input  logic [N_NEURONS*W_WIDTH-1:0]   weight_in,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic [W_WIDTH-1:0]             y
`ifdef ACTIVATION_SAT_FLAG_EN
    ,
    output logic                           sat
`endif
);

    localparam int MAG_W   = W_WIDTH - 1;
    localparam int MAG_MAX = (1 << MAG_W) - 1;
    // Worst-case |sum| is N_NEURONS*MAG_MAX; one extra bit holds the sign.
    localparam int ACC_W   = $clog2(N_NEURONS * MAG_MAX + 1) + 1;
    localparam int CNT_W   = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                         state_reg;
    state_t                         state_next;

    logic [N_NEURONS-1:0]           neurons_reg;
    logic [N_NEURONS*W_WIDTH-1:0]   weight_reg;
    logic signed [ACC_W-1:0]        acc_reg;
    logic [CNT_W-1:0]               cnt_reg;
    logic [W_WIDTH-1:0]             y_reg;

    logic                           accept;
    logic                           last;
    logic [W_WIDTH-1:0]             w_arr [N_NEURONS];
    logic [W_WIDTH-1:0]             w_sel;
    logic signed [ACC_W-1:0]        term;
    logic signed [ACC_W-1:0]        acc_sum;
    logic [ACC_W-1:0]               abs_val;
    logic                           clamp;
    logic [MAG_W-1:0]               mag_next;
    logic [W_WIDTH-1:0]             y_next;

    // Unpack the snapshotted weight bus into one entry per neuron.
    generate
        for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_unpack
            assign w_arr[gi] = weight_reg[gi*W_WIDTH +: W_WIDTH];
        end
    endgenerate

    // Start is honoured only when no evaluation is running.
    assign accept = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign last   = (cnt_reg == CNT_W'(N_NEURONS - 1));
    assign busy   = (state_reg == ACCUM);
    assign done   = (state_reg == DONE);
    assign y      = y_reg;

    // Select the current weight and turn it into a signed addend.
    always_comb begin
        w_sel = w_arr[cnt_reg];
        term  = '0;
        if (neurons_reg[cnt_reg]) begin
            if (w_sel[W_WIDTH-1]) begin
                term = -$signed({{(ACC_W-MAG_W){1'b0}}, w_sel[MAG_W-1:0]});
            end else begin
                term = $signed({{(ACC_W-MAG_W){1'b0}}, w_sel[MAG_W-1:0]});
            end
        end
        acc_sum = acc_reg + term;
    end

    // Convert the final sum to sign-magnitude with clamping; a negative sum
    // is never zero, so a zero result always carries sign 0.
    always_comb begin
        abs_val  = acc_sum[ACC_W-1] ? ACC_W'(-acc_sum) : ACC_W'(acc_sum);
        clamp    = (abs_val > ACC_W'(MAG_MAX));
        mag_next = clamp ? MAG_W'(MAG_MAX) : abs_val[MAG_W-1:0];
        y_next   = {acc_sum[ACC_W-1], mag_next};
    end

    // Next-state logic for the IDLE / ACCUM / DONE sequencer.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (last) state_next = DONE;
            DONE:    state_next = start ? ACCUM : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Snapshot, accumulate and publish the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neurons_reg <= '0;
            weight_reg  <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            y_reg       <= '0;
        end else if (accept) begin
            neurons_reg <= neurons;
            weight_reg  <= weight_in;
            acc_reg     <= '0;
            cnt_reg     <= '0;
        end else if (state_reg == ACCUM) begin
            acc_reg <= acc_sum;
            if (last) begin
                y_reg <= y_next;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

`ifdef ACTIVATION_SAT_FLAG_EN
    // Clamp flag travels with y and holds with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat <= 1'b0;
        end else if ((state_reg == ACCUM) && last && !accept) begin
            sat <= clamp;
        end
    end
`endif

endmodule

// File: tb/tb_activation.sv
// tb_activation: directed vectors with hand-computed results for activation.
module tb_activation;

    localparam int N  = 20;
    localparam int W  = 9;
    localparam int NW = N * W;

    logic           clk;
    logic           rst;
    logic [N-1:0]   neurons;
    logic [NW-1:0]  weight_in;
    logic           start;
    logic           busy;
    logic           done;
    logic [W-1:0]   y;
`ifdef ACTIVATION_SAT_FLAG_EN
    logic           sat;
`endif

    int checks   = 0;
    int failures = 0;

    activation #(.N_NEURONS(N), .W_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .neurons   (neurons),
        .weight_in (weight_in),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .y         (y)
`ifdef ACTIVATION_SAT_FLAG_EN
        ,
        .sat       (sat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Sign-magnitude weight value.
    function automatic logic [W-1:0] sm(input logic s, input int mag);
        logic [W-1:0] r;
        r = {s, 8'(mag)};
        return r;
    endfunction

    // Same weight replicated into every slot.
    function automatic logic [NW-1:0] fill(input logic [W-1:0] w);
        logic [NW-1:0] r;
        for (int j = 0; j < N; j++) r[j*W +: W] = w;
        return r;
    endfunction

    // One evaluation: start at a falling edge, swap inputs to nv2/wv2 one
    // cycle later, then measure latency and check the result.
    task automatic run_eval(input string tag,
                            input logic [N-1:0] nv, input logic [NW-1:0] wv,
                            input logic [N-1:0] nv2, input logic [NW-1:0] wv2,
                            input logic [W-1:0] exp_y, input logic exp_sat);
        int n;
        @(negedge clk);
        neurons   = nv;
        weight_in = wv;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        neurons   = nv2;
        weight_in = wv2;
        n = 1;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd21);
        check({tag, "_y"}, 32'(y), 32'(exp_y));
`ifdef ACTIVATION_SAT_FLAG_EN
        check({tag, "_sat"}, 32'(sat), 32'(exp_sat));
`else
        if (exp_sat) begin end
`endif
        @(negedge clk);
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check({tag, "_y_hold"}, 32'(y), 32'(exp_y));
    endtask

    logic [NW-1:0] wa;
    logic [NW-1:0] wb;
    int            dcount;
    int            prev;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        neurons   = '0;
        weight_in = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_y", 32'(y), 32'd0);
        rst = 1'b0;

        // +100 - 30 = 70
        wa = '0;
        wa[0*W +: W] = sm(1'b0, 100);
        wa[1*W +: W] = sm(1'b1, 30);
        run_eval("basic", 20'h00003, wa, 20'h00003, wa, 9'h046, 1'b0);

        // 20 * 200 = 4000 -> clamp 255
        run_eval("sat_pos", 20'hFFFFF, fill(sm(1'b0, 200)), 20'hFFFFF,
                 fill(sm(1'b0, 200)), 9'h0FF, 1'b1);

        // -4000 -> sign 1, mag 255
        run_eval("sat_neg", 20'hFFFFF, fill(sm(1'b1, 200)), 20'hFFFFF,
                 fill(sm(1'b1, 200)), 9'h1FF, 1'b1);

        // Snapshot: only w0=-5 counts even though inputs change mid-run
        wb = fill(sm(1'b0, 255));
        wb[0*W +: W] = sm(1'b1, 5);
        run_eval("snapshot", 20'h00001, wb, 20'hFFFFF, {NW{1'b1}}, 9'h105, 1'b0);

        // +50 - 50 = 0 with sign 0
        wb = '0;
        wb[0*W +: W] = sm(1'b0, 50);
        wb[1*W +: W] = sm(1'b1, 50);
        run_eval("cancel", 20'h00003, wb, 20'h00003, wb, 9'h000, 1'b0);

        // No neurons active
        run_eval("zero_mask", 20'h00000, fill(sm(1'b0, 77)), 20'h00000,
                 fill(sm(1'b0, 77)), 9'h000, 1'b0);

        // Start held high: done every 21 cycles, no idle gap
        @(negedge clk);
        neurons   = 20'h00003;
        weight_in = wa;
        start     = 1'b1;
        dcount    = 0;
        prev      = 0;
        for (int i = 1; i <= 66; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcount++;
                check($sformatf("b2b_pos%0d", dcount), 32'(i - prev), 32'd21);
                check($sformatf("b2b_y%0d", dcount), 32'(y), 32'h046);
                prev = i;
            end
        end
        check("b2b_count", 32'(dcount), 32'd3);
        start = 1'b0;
        repeat (25) @(negedge clk);
        check("b2b_drained", 32'(busy), 32'd0);

        // Start pulses during ACCUM are ignored
        start  = 1'b1;
        dcount = 0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            start = (i == 3 || i == 8 || i == 15) ? 1'b1 : 1'b0;
            if (done === 1'b1) begin
                dcount++;
                check("ignore_pos", 32'(i), 32'd21);
            end
        end
        check("ignore_count", 32'(dcount), 32'd1);

        // Asynchronous reset in the middle of ACCUM
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_y", 32'(y), 32'd0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        dcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        check("arst_no_done", 32'(dcount), 32'd0);
        check("arst_y_kept", 32'(y), 32'd0);
        run_eval("after_rst", 20'h00003, wa, 20'h00003, wa, 9'h046, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/activation.md
ACTIVATION -- requirements
Module: activation

Interface
REQ-001 SHALL have parameter N_NEURONS, default 20, number of neuron inputs and weights.
REQ-002 SHALL have parameter W_WIDTH, default 9, weight width (bit W_WIDTH-1 sign, remaining bits magnitude).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port neurons  input  N_NEURONS  neuron activity; bit j=1 selects weight j.
REQ-006 SHALL have port weight_in  input  N_NEURONS*W_WIDTH  packed weights; weight j = bits [W_WIDTH*j+W_WIDTH-1 : W_WIDTH*j].
REQ-007 SHALL have port start  input  1  request one evaluation.
REQ-008 SHALL have port busy  output  1  evaluation in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse, y valid and updated.
REQ-010 SHALL have port y  output  W_WIDTH  sign-magnitude result for the weights stage (bit W_WIDTH-1 sign, 1=negative).

Function
REQ-011 SHALL implement FSM states IDLE, ACCUM, DONE; IDLE->ACCUM on start, ACCUM->DONE after N_NEURONS accumulate cycles, DONE->ACCUM if start else IDLE.
REQ-012 SHALL snapshot neurons and weight_in into internal registers on the edge start is accepted; later input changes do not affect the running evaluation.
REQ-013 SHALL clear the signed accumulator and index counter to 0 on start acceptance.
REQ-014 SHALL, in ACCUM, process index j = 0..N_NEURONS-1 one per cycle: add +mag if sign=0, -mag if sign=1, add nothing if neurons[j]=0.
REQ-015 SHALL size the accumulator as two's complement wide enough for N_NEURONS*(2^(W_WIDTH-1)-1) magnitude plus sign (14 bits at defaults); no internal overflow.
REQ-016 SHALL convert on ACCUM->DONE: sign = accumulator negative, magnitude = |accumulator| clamped to 2^(W_WIDTH-1)-1 (255 at defaults); zero result has sign 0.
REQ-017 SHALL register y on ACCUM->DONE and hold it unchanged until the next ACCUM->DONE.
REQ-018 SHALL assert done exactly while in DONE (one cycle); latency start-accepted edge to done high = N_NEURONS+1 cycles (21 at defaults).
REQ-019 SHALL assert busy in ACCUM only; busy low in IDLE and DONE.
REQ-020 SHALL ignore start while in ACCUM (no restart, no queueing).
REQ-021 SHALL accept start during DONE, beginning the next evaluation with no idle cycle (back-to-back throughput N_NEURONS+1 cycles).
REQ-022 SHALL treat neurons all-zero as result y = 0 after full latency.

Reset
REQ-023 SHALL on rst high immediately force state IDLE, busy=0, done=0, y=0, accumulator=0, counter=0, snapshots=0.
REQ-024 SHALL abandon an in-progress evaluation on rst with no done pulse and no y update.
REQ-025 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-026 SHALL, with macro ACTIVATION_SAT_FLAG_EN defined, add output port sat (1 bit, reset 0), registered with y, high when the magnitude was clamped in REQ-016, held with y.
REQ-027 SHALL, without ACTIVATION_SAT_FLAG_EN, omit port sat and its logic; all other behaviour identical.

Verification
REQ-028 SHALL test: neurons=0x00003, w0=+100, w1=-30, start -> done at cycle 21, y = sign 0, mag 70.
REQ-029 SHALL test: all 20 neurons on, all weights +200 -> y = sign 0, mag 255; sat=1 when ACTIVATION_SAT_FLAG_EN.
REQ-030 SHALL test: neurons=0x00001, w0=-5, w1..w19=+255, inputs changed to all-ones one cycle after start -> y = sign 1, mag 5.
REQ-031 SHALL test: start held high continuously -> done pulses every 21 cycles, start pulses during busy produce no extra done.
REQ-032 SHALL test: rst asserted at cycle 10 of ACCUM -> busy, done, y go 0 asynchronously; no done follows; new start after release yields correct result.
REQ-033 SHALL test: w0=+50, w1=-50, neurons=0x00003 -> y = 0x000 (sign 0, mag 0).
